// File: rtl/pipe_pkg.sv
// Shared definitions for the pipelined core's stage-boundary registers.
// Holds default payload/counter widths, control-field bit positions and the
// packed control payload type used by the decode and execute stages.
package pipe_pkg;

    // Default widths for pipe_stage_reg instances
    localparam int unsigned DEF_DATA_W = 40;
    localparam int unsigned DEF_CTRL_W = 8;
    localparam int unsigned DEF_CNT_W  = 16;

    // Control payload bit positions
    localparam int unsigned CTRL_REGWRITE  = 0;
    localparam int unsigned CTRL_ALUSRC    = 1;
    localparam int unsigned CTRL_RESULTSRC = 2;
    localparam int unsigned CTRL_MEMWRITE  = 3;
    localparam int unsigned CTRL_ALUOP_LSB = 4;
    localparam int unsigned CTRL_ALUOP_MSB = 6;
    localparam int unsigned CTRL_MATMUL    = 7;

    // Control payload, msb first; matches the bit positions above
    typedef struct packed {
        logic       matmul;
        logic [2:0] aluop;
        logic       memwrite;
        logic       resultsrc;
        logic       alusrc;
        logic       regwrite;
    } ctrl_t;

endpackage : pipe_pkg

// File: rtl/pipe_skid_slot.sv
// Single-entry skid slot (S) for pipe_stage_reg.
// Ports:
//   clk, reset       clock, async active-high reset
//   flush_i          empties the slot (highest priority)
//   wr_en_i          capture data_i/ctrl_i and mark the slot full
//   rd_en_i          slot contents consumed; mark empty
//   data_i, ctrl_i   payload to park
//   valid_o          slot holds a beat
//   data_o, ctrl_o   parked payload
module pipe_skid_slot
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CTRL_W = DEF_CTRL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;

    // Next-state: flush beats a write, a write beats a read
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (wr_en_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            ctrl_d  = ctrl_i;
        end else if (rd_en_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign ctrl_o  = ctrl_q;

endmodule : pipe_skid_slot

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB boundaries).
// Carries a data and a control payload across a valid/ready handshake, with
// flush, a saturating bubble counter and an optional skid entry.
// Build option: define PIPE_STAGE_REG_SKID_EN to add the skid entry, which
// makes in_ready a registered signal with no path from out_ready.
// Ports:
//   clk, reset                 clock, async active-high reset
//   in_valid/in_ready          upstream handshake
//   in_data, in_ctrl           upstream payload
//   out_valid/out_ready        downstream handshake
//   out_data, out_ctrl         registered payload (main register M)
//   flush                      kill held beats and any beat accepted this cycle
//   cnt_clr                    clear bubble_cnt
//   bubble_cnt                 saturating count of cycles with out_valid=0
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CTRL_W = DEF_CTRL_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q,  m_data_d;
    logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    logic              accept;
    logic              xfer;
    logic              m_load;
    logic [DATA_W-1:0] m_load_data;
    logic [CTRL_W-1:0] m_load_ctrl;

    assign accept = in_valid && in_ready;
    assign xfer   = m_valid_q && out_ready;

`ifdef PIPE_STAGE_REG_SKID_EN
    logic              s_valid;
    logic              s_wr;
    logic              s_rd;
    logic [DATA_W-1:0] s_data;
    logic [CTRL_W-1:0] s_ctrl;

    // S is only ever full while M is full, so !S.valid is the capacity signal
    assign in_ready = !s_valid;
    // Park the beat only when M is full and not draining this cycle
    assign s_wr     = accept && m_valid_q && !out_ready;
    assign s_rd     = s_valid && xfer;

    pipe_skid_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .flush_i (flush),
        .wr_en_i (s_wr),
        .rd_en_i (s_rd),
        .data_i  (in_data),
        .ctrl_i  (in_ctrl),
        .valid_o (s_valid),
        .data_o  (s_data),
        .ctrl_o  (s_ctrl)
    );

    // M refill source: the older parked beat first, else the incoming beat
    always_comb begin
        m_load      = 1'b0;
        m_load_data = in_data;
        m_load_ctrl = in_ctrl;
        if (s_rd) begin
            m_load      = 1'b1;
            m_load_data = s_data;
            m_load_ctrl = s_ctrl;
        end else if (accept && (!m_valid_q || out_ready)) begin
            m_load = 1'b1;
        end
    end
`else
    // Without S, accept only when M is empty or draining this cycle
    assign in_ready = !m_valid_q || out_ready;

    always_comb begin
        m_load      = accept;
        m_load_data = in_data;
        m_load_ctrl = in_ctrl;
    end
`endif

    // Main register next-state; flush zeroes ctrl so a killed beat is inert
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_ctrl_d  = m_ctrl_q;
        if (flush) begin
            m_valid_d = 1'b0;
            m_ctrl_d  = '0;
        end else if (m_load) begin
            m_valid_d = 1'b1;
            m_data_d  = m_load_data;
            m_ctrl_d  = m_load_ctrl;
        end else if (xfer) begin
            m_valid_d = 1'b0;
        end
    end

    // Bubble counter: clear wins, otherwise saturating count of empty cycles
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (!m_valid_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_ctrl_q  <= '0;
            cnt_q     <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_ctrl_q  <= m_ctrl_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_valid  = m_valid_q;
    assign out_data   = m_data_q;
    assign out_ctrl   = m_ctrl_q;
    assign bubble_cnt = cnt_q;

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg (CNT_W=4 so saturation is reachable).
// The reference model is a FIFO of held beats plus a saturating integer.
module tb_pipe_stage_reg;

    localparam int unsigned DATA_W  = 40;
    localparam int unsigned CTRL_W  = 8;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned BEAT_W  = DATA_W + CTRL_W;
    localparam int unsigned BUB_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic              flush;
    logic              cnt_clr;
    logic [CNT_W-1:0]  bubble_cnt;

    logic [BEAT_W-1:0] mq[$];
    int unsigned       mbub;
    int                checks;
    int                errors;
    int unsigned       seq;

    pipe_stage_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ctrl   (out_ctrl),
        .flush      (flush),
        .cnt_clr    (cnt_clr),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capacity rule: two beats with the skid entry, otherwise one plus pass-through
    function automatic bit exp_in_ready(input bit ordy);
`ifdef PIPE_STAGE_REG_SKID_EN
        return mq.size() < 2;
`else
        return (mq.size() == 0) || ordy;
`endif
    endfunction

    // One clock: drive at negedge, check, then advance the model at posedge
    task automatic cycle(input logic v, input logic [DATA_W-1:0] d,
                         input logic [CTRL_W-1:0] c, input logic ordy,
                         input logic fl, input logic clr);
        bit er;
        bit acc;
        bit xf;
        int hb;
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        cnt_clr   = clr;
        #1;
        er = exp_in_ready(ordy);
        checks++;
        if (in_ready !== er) begin
            errors++;
            $display("FAIL in_ready @%0t: got %b expected %b", $time, in_ready, er);
        end
        checks++;
        if (out_valid !== (mq.size() > 0)) begin
            errors++;
            $display("FAIL out_valid @%0t: got %b expected %b", $time, out_valid, mq.size() > 0);
        end
        if (mq.size() > 0) begin
            checks++;
            if ({out_data, out_ctrl} !== mq[0]) begin
                errors++;
                $display("FAIL out_payload @%0t: got %h/%h expected %h", $time, out_data, out_ctrl, mq[0]);
            end
        end
        checks++;
        if (bubble_cnt !== CNT_W'(mbub)) begin
            errors++;
            $display("FAIL bubble_cnt @%0t: got %0d expected %0d", $time, bubble_cnt, mbub);
        end
        acc = v && er;
        hb  = mq.size();
        xf  = (hb > 0) && ordy;
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (xf)  void'(mq.pop_front());
            if (acc) mq.push_back({d, c});
        end
        if (clr) mbub = 0;
        else if (hb == 0 && mbub < BUB_MAX) mbub++;
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy, input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, ordy, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        // Values while reset is held from power-up
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0 || bubble_cnt !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_init: got v=%b c=%h d=%h b=%0d r=%b expected 0/0/0/0/1",
                     out_valid, out_ctrl, out_data, bubble_cnt, in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        // Load beats and a few bubbles, then reset asynchronously mid-stream
        idle(1'b1, 3);
        cycle(1'b1, 40'h11, 8'hC3, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 40'h22, 8'h3C, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || bubble_cnt !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_async: got v=%b c=%h b=%0d r=%b expected 0/00/0/1",
                     out_valid, out_ctrl, bubble_cnt, in_ready);
        end
        mq.delete();
        mbub = 0;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_stream();
        cycle(1'b1, DATA_W'(1), 8'hA4, 1'b1, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== DATA_W'(1)) begin
            errors++;
            $display("FAIL stream_latency: got v=%b d=%h expected 1/01", out_valid, out_data);
        end
        for (int i = 2; i <= 16; i++)
            cycle(1'b1, DATA_W'(i), CTRL_W'(i) ^ 8'hA5, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 2);
    endtask

    task automatic test_backpressure();
`ifdef PIPE_STAGE_REG_SKID_EN
        cycle(1'b1, 40'hAA, 8'h0A, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 40'hBB, 8'h0B, 1'b0, 1'b0, 1'b0);
        checks++;
        if (in_ready !== 1'b0 || out_data !== 40'hAA) begin
            errors++;
            $display("FAIL skid_full: got r=%b d=%h expected 0/aa", in_ready, out_data);
        end
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 40'hBB) begin
            errors++;
            $display("FAIL skid_drain: got r=%b v=%b d=%h expected 1/1/bb", in_ready, out_valid, out_data);
        end
        idle(1'b1, 2);
`else
        cycle(1'b1, 40'hAA, 8'h0A, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 40'hBB, 8'h0B, 1'b0, 1'b0, 1'b0);
        checks++;
        if (in_ready !== 1'b0 || out_data !== 40'hAA) begin
            errors++;
            $display("FAIL bp_full: got r=%b d=%h expected 0/aa", in_ready, out_data);
        end
        cycle(1'b1, 40'hBB, 8'h0B, 1'b1, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 40'hBB) begin
            errors++;
            $display("FAIL bp_replace: got v=%b d=%h expected 1/bb", out_valid, out_data);
        end
        idle(1'b1, 2);
`endif
    endtask

    task automatic test_flush();
        logic [DATA_W-1:0] old;
        cycle(1'b1, 40'h12_3456_789A, 8'hFF, 1'b0, 1'b0, 1'b0);
        old = out_data;
        cycle(1'b1, 40'hDE_AD00_BEEF, 8'h5A, 1'b1, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || out_data !== 40'h12_3456_789A) begin
            errors++;
            $display("FAIL flush: got v=%b c=%h d=%h expected 0/00/%h", out_valid, out_ctrl, out_data, old);
        end
        idle(1'b1, 3);
    endtask

    task automatic test_bubble();
        idle(1'b1, 20);
        checks++;
        if (bubble_cnt !== 4'd15) begin
            errors++;
            $display("FAIL bubble_sat: got %0d expected 15", bubble_cnt);
        end
        cycle(1'b1, 40'h77, 8'h07, 1'b1, 1'b0, 1'b1);
        checks++;
        if (bubble_cnt !== 4'd0) begin
            errors++;
            $display("FAIL bubble_clr: got %0d expected 0", bubble_cnt);
        end
        for (int i = 0; i < 10; i++)
            cycle(1'b1, DATA_W'(32'h100 + i), CTRL_W'(i), 1'b1, 1'b0, 1'b0);
        checks++;
        if (bubble_cnt !== 4'd0) begin
            errors++;
            $display("FAIL bubble_stream: got %0d expected 0", bubble_cnt);
        end
        idle(1'b1, 2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10000; i++) begin
            seq++;
            cycle(($urandom % 4) != 0, DATA_W'(seq), CTRL_W'($urandom),
                  ($urandom % 3) != 0, ($urandom % 64) == 0, ($urandom % 97) == 0);
        end
        idle(1'b1, 4);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL random_drain: got out_valid=%b expected 0", out_valid);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        mbub      = 0;
        seq       = 32'h1000;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        cnt_clr   = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_bubble();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pipe_stage_reg

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, elastic pipeline-stage register for the 8-bit pipelined core. It replaces the fixed per-stage boundary registers such as ID/EX with one generic block carrying a data payload and a control payload. Upstream and downstream are joined by a valid/ready handshake, and the block supports flush, an optional skid buffer and a saturating bubble counter. Instances sit between every pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
Parameters:
- DATA_W, default 40: data payload width (operands, PC+1, immediate, register indices).
- CTRL_W, default 8: control payload width (RegWrite, ALUSrc, ResultSrc, MemWrite, ALUControl, mode bits).
- CNT_W, default 16: bubble counter width.

Ports:
- clk  in  1  rising-edge clock; one clock domain.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- in_data  in  DATA_W  upstream data payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- out_valid  out  1  output register holds a live beat.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DATA_W  registered data payload.
- out_ctrl  out  CTRL_W  registered control payload.
- flush  in  1  synchronous kill of every held beat and of any beat accepted this cycle.
- cnt_clr  in  1  synchronous clear of bubble_cnt.
- bubble_cnt  out  CNT_W  saturating count of cycles with out_valid=0.

## Operation
- Accept happens on in_valid && in_ready. Transfer out happens on out_valid && out_ready.
- Main register M drives the out_* ports. Beats leave in strict arrival order, with no loss and no duplication.
- Reset values: out_valid=0, out_data=0, out_ctrl=0, bubble_cnt=0, skid entry empty, in_ready=1.
- Flush has priority over everything else:
  - out_valid becomes 0 and out_ctrl becomes 0 on the next edge.
  - out_data holds its old value.
  - The skid entry is emptied.
  - A beat offered in the same cycle completes its handshake (in_ready unaffected) and is dropped.
- Zeroing out_ctrl guarantees a killed beat can never assert RegWrite or MemWrite downstream.
- An accepted beat loads M when M is empty or is transferring out this cycle. Otherwise it is held according to the skid configuration (see Configuration).
- bubble_cnt:
  - Increments by 1 each cycle that out_valid=0 and saturates at 2^CNT_W-1; it does not wrap.
  - cnt_clr takes priority and sets it to 0 on the next edge.
  - The count includes flush-induced bubbles.

## Timing
- Latency is 1 cycle: a beat accepted at edge N appears on out_* after edge N.
- Throughput is 1 beat per cycle while out_ready=1.
- With the skid buffer, a beat held in skid appears on out_* the cycle after out_ready first rises.
- Reset asserted mid-operation drops all beats immediately (asynchronously). The first accept is possible on the first edge after reset deasserts.
- Simultaneous transfer out and accept with M full: the new beat replaces M on that edge, with no bubble.

## Configuration
- PIPE_STAGE_REG_SKID_EN defined:
  - Adds skid entry S; in_ready is a register output, equal to !S.valid.
  - If M is full, out_ready=0 and a beat is accepted, the beat goes to S. in_ready falls after that edge.
  - On a later transfer out, S moves to M and in_ready rises after that edge.
  - There is no combinational path from out_ready to in_ready.
- PIPE_STAGE_REG_SKID_EN undefined:
  - No S register.
  - in_ready = !out_valid || out_ready, combinationally.
  - Same cycle behaviour otherwise.

## Structure
- Shared package pipe_pkg holds:
  - default widths (DATA_W, CTRL_W, CNT_W);
  - control-field bit positions (CTRL_REGWRITE, CTRL_ALUSRC, CTRL_RESULTSRC, CTRL_MEMWRITE, CTRL_ALUOP lsb/msb, CTRL_MATMUL);
  - a packed ctrl_t typedef.
- One sub-module, pipe_skid_slot, holds S (data, ctrl, valid). It is instantiated only under PIPE_STAGE_REG_SKID_EN.

## Test plan
- Reset then stream: drive reset=1 mid-stream → out_valid=0, out_ctrl=0, bubble_cnt=0 immediately. Release and stream 0x01..0x10 with out_ready=1 → the same sequence out, one per cycle, 1-cycle latency.
- Backpressure (skid on): send A then B with out_ready=0 → A held in M, B held in S, in_ready=0. Raise out_ready → A then B on consecutive cycles, then in_ready=1.
- Backpressure (skid off): out_ready=0 with M full → in_ready=0 in the same cycle and no beat lost.
- Flush: M holds ctrl=0xFF and a new beat is offered with flush=1 → next cycle out_valid=0, out_ctrl=0x00, out_data unchanged, and the offered beat never appears.
- Bubble counter: CNT_W=4, idle 20 cycles → bubble_cnt saturates at 15. Pulse cnt_clr → 0. Stream continuously → stays 0.
- Randomised in_valid/out_ready for 10k cycles → output order matches a scoreboard and no beat is duplicated.
